// File: rtl/pent_dram_pkg.sv
// pent_dram_pkg: phase/page constants, slot kinds and address helpers for pent_dram_seq
package pent_dram_pkg;
  localparam logic [2:0] PH_VROW  = 3'd0;
  localparam logic [2:0] PH_VCOL  = 3'd1;
  localparam logic [2:0] PH_VCAS  = 3'd2;
  localparam logic [2:0] PH_VDATA = 3'd3;
  localparam logic [2:0] PH_CROW  = 3'd4;
  localparam logic [2:0] PH_CCOL  = 3'd5;
  localparam logic [2:0] PH_CCAS  = 3'd6;
  localparam logic [2:0] PH_CDATA = 3'd7;
  localparam logic [2:0] PG_SCR0 = 3'd5;
  localparam logic [2:0] PG_SCR1 = 3'd7;
  localparam logic [2:0] PG_4000 = 3'd5;
  localparam logic [2:0] PG_8000 = 3'd2;
  typedef enum logic [1:0] {IDLE, CPU_ACC, REFRESH} slot_kind_t;
  // {row, col} source: bank bit page[2] is carried by CAS, not by the address
  function automatic logic [15:0] dram_addr(input logic [2:0] page, input logic [13:0] addr);
    return {page[1:0], addr};
  endfunction
  function automatic logic [1:0] cas_mask(input logic bank);
    return bank ? 2'b01 : 2'b10;
  endfunction
endpackage

// File: rtl/pent_dram_refresh.sv
// pent_dram_refresh: refresh interval counter and pending-request flag
// clk, rst_n (async, active low); tick = end of an 8-phase slot; clr = refresh
// serviced; pend = refresh request outstanding.
module pent_dram_refresh #(
  parameter int REF_INT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic clr,
  output logic pend
);
  localparam logic [7:0] RELOAD = 8'(REF_INT - 1);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= RELOAD;
      pend <= 1'b0;
    end else begin
      if (tick) cnt <= cnt == 8'd0 ? RELOAD : cnt - 8'd1;
      // expiry outranks a same-edge clear; requests do not queue
      pend <= (tick && cnt == 8'd0) ? 1'b1 : clr ? 1'b0 : pend;
    end
endmodule

// File: rtl/pent_dram_seq.sv
// pent_dram_seq: 8-phase DRAM sequencer sharing 128K between video (PH0-3) and CPU (PH4-7)
// In : CLK, RESETn (async, active low), MREQn/WRn/RFSHn/A from the Z80,
//      PAGE/SCR from the 7FFD latch, VA from the raster counter.
// Out: MA, RASn, CASn[1:0] (bit0 pages 0-3, bit1 pages 4-7), WEn, VLATCH,
//      CLATCH, PH, REF_PEND. All outputs registered.
// PENT_CPU_RFSH_EN: Z80 refresh cycles become RAS-only refreshes and the
//      internal CBR refresh is removed (REF_PEND tied low).
module pent_dram_seq
  import pent_dram_pkg::*;
#(
  parameter int REF_INT = 16,
  parameter int MA_W = 8
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            MREQn,
  input  logic            WRn,
  input  logic            RFSHn,
  input  logic [15:0]     A,
  input  logic [2:0]      PAGE,
  input  logic            SCR,
  input  logic [13:0]     VA,
  output logic [MA_W-1:0] MA,
  output logic            RASn,
  output logic [1:0]      CASn,
  output logic            WEn,
  output logic            VLATCH,
  output logic            CLATCH,
  output logic [2:0]      PH,
  output logic            REF_PEND
);
  logic [2:0] ph_n, pg_q, cpu_pg, vid_pg;
  logic [13:0] a_q, addr;
  logic [15:0] vid_pa, cpu_pa;
  logic wr_q, wr, smp, vid, acc, rf;
  slot_kind_t kind_q, kind, kind_live;
  logic [MA_W-1:0] ma_d;
  logic ras_d, we_d, vl_d, cl_d;
  logic [1:0] cas_d;
`ifdef PENT_CPU_RFSH_EN
  assign REF_PEND = 1'b0;
`else
  pent_dram_refresh #(.REF_INT(REF_INT)) u_ref (
    .clk(CLK),
    .rst_n(RESETn),
    .tick(PH == PH_CDATA),
    .clr(rf && ph_n == PH_CCAS),
    .pend(REF_PEND)
  );
`endif
  // outputs are computed for the phase being entered (ph_n) so they appear aligned with PH
  always_comb begin
    ph_n = PH + 3'd1;
    smp = ph_n == PH_CROW;
`ifdef PENT_CPU_RFSH_EN
    kind_live = MREQn ? IDLE : !RFSHn ? REFRESH : A[15:14] != 2'b00 ? CPU_ACC : IDLE;
`else
    kind_live = (!MREQn && RFSHn && A[15:14] != 2'b00) ? CPU_ACC : REF_PEND ? REFRESH : IDLE;
`endif
    kind = smp ? kind_live : kind_q;
    addr = smp ? A[13:0] : a_q;
    wr = smp ? WRn : wr_q;
    cpu_pg = smp ? (A[15:14] == 2'b01 ? PG_4000 : A[15:14] == 2'b10 ? PG_8000 : PAGE) : pg_q;
    vid_pg = SCR ? PG_SCR1 : PG_SCR0;
    vid_pa = dram_addr(vid_pg, VA);
    cpu_pa = dram_addr(cpu_pg, addr);
    vid = !ph_n[2];
    acc = ph_n[2] && kind == CPU_ACC;
    rf = ph_n[2] && kind == REFRESH;
    ma_d = vid ? (ph_n == PH_VROW ? MA_W'(vid_pa[7:0]) : ph_n == PH_VCOL ? MA_W'(vid_pa[15:8]) : MA)
         : acc ? (ph_n == PH_CROW ? MA_W'(cpu_pa[7:0]) : ph_n == PH_CCOL ? MA_W'(cpu_pa[15:8]) : MA)
         : MA;
    ras_d = !(vid ? ph_n != PH_VROW : acc ? ph_n != PH_CROW : rf && (ph_n == PH_CCOL || ph_n == PH_CCAS));
    cas_d = (vid && ph_n >= PH_VCAS) ? cas_mask(vid_pg[2])
          : (acc && ph_n >= PH_CCAS) ? cas_mask(cpu_pg[2]) : 2'b11;
    we_d = (acc && ph_n >= PH_CCOL) ? wr : 1'b1;
    vl_d = ph_n == PH_VDATA;
    cl_d = acc && ph_n == PH_CDATA && wr;
`ifdef PENT_CPU_RFSH_EN
    if (rf && ph_n == PH_CROW) ma_d = MA_W'(addr[7:0]);
`else
    if (rf && ph_n != PH_CDATA) cas_d = 2'b00;
`endif
  end
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      PH <= PH_VROW;
      MA <= '0;
      RASn <= 1'b1;
      CASn <= 2'b11;
      WEn <= 1'b1;
      VLATCH <= 1'b0;
      CLATCH <= 1'b0;
      kind_q <= IDLE;
      a_q <= '0;
      wr_q <= 1'b1;
      pg_q <= '0;
    end else begin
      PH <= ph_n;
      MA <= ma_d;
      RASn <= ras_d;
      CASn <= cas_d;
      WEn <= we_d;
      VLATCH <= vl_d;
      CLATCH <= cl_d;
      kind_q <= kind;
      a_q <= addr;
      wr_q <= wr;
      pg_q <= cpu_pg;
    end
endmodule

// File: tb/tb_pent_dram_seq.sv
// tb_pent_dram_seq: directed self-checking bench for pent_dram_seq with REF_INT=4
module tb_pent_dram_seq;
  logic CLK = 1'b0, RESETn = 1'b0, MREQn = 1'b1, WRn = 1'b1, RFSHn = 1'b1, SCR = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [2:0] PAGE = 3'd0;
  logic [13:0] VA = 14'h0000;
  logic [7:0] MA;
  logic RASn, WEn, VLATCH, CLATCH, REF_PEND;
  logic [1:0] CASn;
  logic [2:0] PH;
  int checks = 0, errors = 0;
  int p;
  bit rslot;
  always #5 CLK = ~CLK;
  pent_dram_seq #(.REF_INT(4), .MA_W(8)) dut (
    .CLK(CLK), .RESETn(RESETn), .MREQn(MREQn), .WRn(WRn), .RFSHn(RFSHn),
    .A(A), .PAGE(PAGE), .SCR(SCR), .VA(VA),
    .MA(MA), .RASn(RASn), .CASn(CASn), .WEn(WEn),
    .VLATCH(VLATCH), .CLATCH(CLATCH), .PH(PH), .REF_PEND(REF_PEND)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic wait_ph(input logic [2:0] ph);
    for (int k = 0; k < 16 && PH !== ph; k++) step();
    if (PH !== ph) check("wait_ph", 32'(PH), 32'(ph));
  endtask
  initial begin
    @(negedge CLK);
    check("rst_ph", PH, 0);
    check("rst_ma", MA, 0);
    check("rst_rasn", RASn, 1);
    check("rst_casn", CASn, 2'b11);
    check("rst_wen", WEn, 1);
    check("rst_vlatch", VLATCH, 0);
    check("rst_clatch", CLATCH, 0);
    check("rst_ref_pend", REF_PEND, 0);
    RESETn = 1'b1;
    // idle CPU: video every slot, refresh requested after the 4th PH7, serviced in slot 4
    for (int n = 1; n <= 40; n++) begin
      step();
      p = n % 8;
      rslot = (n / 8) == 4;
      check("ph", PH, 32'(p));
      check("vlatch", VLATCH, p == 3);
      check("ref_pend", REF_PEND, n >= 32 && n < 38);
      check("rasn", RASn, !((p >= 1 && p <= 3) || (rslot && (p == 5 || p == 6))));
      check("casn", CASn, (p == 2 || p == 3) ? 2'b01 : (rslot && p >= 4 && p <= 6) ? 2'b00 : 2'b11);
      check("ma", MA, p == 0 ? 8'h00 : 8'h40);
      check("wen", WEn, 1);
      check("clatch", CLATCH, 0);
    end
    // video from page 7: 16'hDABC
    wait_ph(3'd7);
    SCR = 1'b1;
    VA = 14'h1ABC;
    step();
    check("vid_row", MA, 8'hBC);
    check("vid_row_rasn", RASn, 1);
    step();
    check("vid_col", MA, 8'hDA);
    check("vid_col_rasn", RASn, 0);
    check("vid_col_casn", CASn, 2'b11);
    step();
    check("vid_ph2_casn", CASn, 2'b01);
    step();
    check("vid_ph3_casn", CASn, 2'b01);
    check("vid_ph3_vlatch", VLATCH, 1);
    // CPU read C123 from page 3
    MREQn = 1'b0; WRn = 1'b1; A = 16'hC123; PAGE = 3'd3;
    step();
    check("rd_row", MA, 8'h23);
    check("rd_ph4_rasn", RASn, 1);
    check("rd_ph4_casn", CASn, 2'b11);
    MREQn = 1'b1; A = 16'h0000;
    step();
    check("rd_col", MA, 8'hC1);
    check("rd_ph5_rasn", RASn, 0);
    check("rd_ph5_wen", WEn, 1);
    step();
    check("rd_ph6_casn", CASn, 2'b10);
    check("rd_ph6_clatch", CLATCH, 0);
    step();
    check("rd_ph7_casn", CASn, 2'b10);
    check("rd_ph7_clatch", CLATCH, 1);
    check("rd_ph7_wen", WEn, 1);
    step();
    check("rd_ph0_clatch", CLATCH, 0);
    // CPU write 8005 -> page 2, WRn raised late must not matter
    wait_ph(3'd3);
    MREQn = 1'b0; WRn = 1'b0; A = 16'h8005;
    step();
    check("wr_row", MA, 8'h05);
    check("wr_ph4_wen", WEn, 1);
    MREQn = 1'b1;
    step();
    check("wr_col", MA, 8'h80);
    check("wr_ph5_wen", WEn, 0);
    check("wr_ph5_rasn", RASn, 0);
    check("wr_ph5_casn", CASn, 2'b11);
    WRn = 1'b1;
    step();
    check("wr_ph6_wen", WEn, 0);
    check("wr_ph6_casn", CASn, 2'b10);
    step();
    check("wr_ph7_wen", WEn, 0);
    check("wr_ph7_casn", CASn, 2'b10);
    check("wr_ph7_clatch", CLATCH, 0);
    step();
    check("wr_ph0_wen", WEn, 1);
    check("wr_ph0_casn", CASn, 2'b11);
    check("ref_pend_set", REF_PEND, 1);
    // ROM access with a refresh pending: refresh runs, MA untouched
    wait_ph(3'd3);
    MREQn = 1'b0; WRn = 1'b1; A = 16'h0100;
    step();
    check("rom_ph4_casn", CASn, 2'b00);
    check("rom_ph4_rasn", RASn, 1);
    check("rom_ph4_ma", MA, 8'hDA);
    check("rom_ph4_wen", WEn, 1);
    step();
    check("rom_ph5_rasn", RASn, 0);
    check("rom_ph5_casn", CASn, 2'b00);
    check("rom_ph5_ref_pend", REF_PEND, 1);
    step();
    check("rom_ph6_ref_pend", REF_PEND, 0);
    check("rom_ph6_rasn", RASn, 0);
    check("rom_ph6_casn", CASn, 2'b00);
    step();
    check("rom_ph7_casn", CASn, 2'b11);
    check("rom_ph7_rasn", RASn, 1);
    check("rom_ph7_clatch", CLATCH, 0);
    MREQn = 1'b1;
    // async reset in PH6 of a write to page 4
    wait_ph(3'd3);
    MREQn = 1'b0; WRn = 1'b0; A = 16'hC000; PAGE = 3'd4;
    step();
    step();
    step();
    check("ar_ph6_casn", CASn, 2'b01);
    check("ar_ph6_wen", WEn, 0);
    check("ar_ph6_rasn", RASn, 0);
    #2 RESETn = 1'b0;
    #1;
    check("ar_rasn", RASn, 1);
    check("ar_casn", CASn, 2'b11);
    check("ar_wen", WEn, 1);
    check("ar_ph", PH, 0);
    MREQn = 1'b1; WRn = 1'b1;
    @(negedge CLK);
    RESETn = 1'b1;
    check("ar_rel_ph", PH, 0);
    step();
    check("ar_first_ph", PH, 1);
    check("ar_first_rasn", RASn, 0);
    check("ar_first_ma", MA, 8'hDA);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pent_dram_seq.md
Name: pent_dram_seq

Overview:
- 8-phase DRAM sequencer directly downstream of the 7FFD paging latch.
- Consumes the latched page bits and screen-select bit, and multiplexes 128K of DRAM between a video fetch slot and a CPU slot.
- Drives row/column address, RAS, per-bank CAS, WE and data-latch strobes.
- Refreshes the DRAM with CAS-before-RAS cycles in idle CPU slots.

Parameters:
- REF_INT, 16: number of 8-phase slots between refresh requests (range 2..255).
- MA_W, 8: width of the multiplexed DRAM address bus.

Ports:
- CLK  in  1  14 MHz pixel clock; one phase per rising edge.
- RESETn  in  1  asynchronous active-low reset.
- MREQn  in  1  Z80 memory request, active low.
- WRn  in  1  Z80 write strobe, active low.
- RFSHn  in  1  Z80 refresh indicator, active low.
- A  in  16  Z80 address bus.
- PAGE  in  3  RAM page for the C000-FFFF window, from the paging latch.
- SCR  in  1  screen select, from the paging latch: 0 = page 5, 1 = page 7.
- VA  in  14  video address from the raster counter.
- MA  out  MA_W  multiplexed DRAM address.
- RASn  out  1  row strobe, shared by both banks.
- CASn  out  2  column strobes; bit0 = pages 0-3, bit1 = pages 4-7.
- WEn  out  1  DRAM write enable.
- VLATCH  out  1  one-clock strobe: video data valid.
- CLATCH  out  1  one-clock strobe: CPU read data valid.
- PH  out  3  current phase.
- REF_PEND  out  1  refresh request outstanding.

Behaviour:
- Reset values, applied asynchronously: PH=0, MA=0, RASn=1, CASn=2'b11, WEn=1, VLATCH=0, CLATCH=0, REF_PEND=0, refresh counter=REF_INT-1.
  - Reset asserted mid-cycle aborts the cycle immediately.
  - The first cycle after release starts at PH0.
- All outputs are registered.
- PH increments every CLK and wraps 7->0.
- Physical address = {page[2:0], addr[13:0]}.
  - bank = page[2]
  - row = {page[1:0], addr[13:0]}[7:0]
  - col = {page[1:0], addr[13:0]}[15:8]
- Video slot, PH0-3, runs every slot unconditionally. Page = SCR ? 7 : 5; addr = VA.
  - PH0: MA=row.
  - PH1: RASn=0, MA=col.
  - PH2-3: CASn[bank]=0.
  - PH3: VLATCH=1.
  - At PH4 RASn, CASn and VLATCH return to idle.
- CPU slot, PH4-7. At the PH4 edge the block samples MREQn, RFSHn, WRn and A and holds them until PH7 completes. The decision is:
  - CPU_ACC when MREQn=0, RFSHn=1 and A[15:14] != 2'b00. A[15:14]=00 is ROM and never touches DRAM.
  - Otherwise REFRESH when REF_PEND=1.
  - Otherwise IDLE.
- Page selection for CPU_ACC, by A[15:14]: 01 -> page 5; 10 -> page 2; 11 -> PAGE.
- CPU_ACC sequence:
  - PH4: MA=row.
  - PH5: RASn=0, MA=col, WEn=WRn(sampled).
  - PH6-7: CASn[bank]=0.
  - PH7: CLATCH=1, only when the sampled WRn=1.
- REFRESH sequence, CAS-before-RAS:
  - PH4-6: CASn=2'b00.
  - PH5-6: RASn=0.
  - PH6 edge: REF_PEND clears.
  - MA and WEn are held idle throughout.
- IDLE: all strobes inactive, MA holds its last value.
- Changes to MREQn or WRn after the PH4 sample do not abort or modify the current access.
- Refresh counter:
  - Decrements at each PH7.
  - On reaching 0 it reloads REF_INT-1 and sets REF_PEND.
  - If REF_PEND is still set on expiry, it stays set; requests do not queue.
  - If a set and a clear happen on the same edge, set wins.
- Invariant: RASn and CASn are never both high-to-low in the same edge, and WEn changes only while CASn=2'b11.

Optional Feature:
- Macro: PENT_CPU_RFSH_EN.
- Defined: a CPU slot sampled with MREQn=0 and RFSHn=0 performs a RAS-only refresh.
  - PH4: MA=A[7:0].
  - PH5-6: RASn=0.
  - CASn stays high.
  - The internal counter and the REFRESH state are removed, and REF_PEND is tied to 0.
- Undefined: RFSHn cycles are treated as IDLE, and the internal CBR refresh described above is used.

Decomposition:
- Package pent_dram_pkg holds:
  - phase constants PH_VROW..PH_CDATA (0-7);
  - page constants PG_SCR0=5, PG_SCR1=7, PG_4000=5, PG_8000=2;
  - slot-kind enum {IDLE, CPU_ACC, REFRESH}.
- One natural sub-module, pent_dram_refresh: the interval counter plus the REF_PEND set/clear logic, parameterised by REF_INT.

Test Plan:
- Release reset, hold MREQn=1, REF_INT=4 -> VLATCH pulses at every PH3; REF_PEND rises after the 4th PH7; the next slot shows CASn=00 at PH4-6, RASn=0 at PH5-6, and REF_PEND=0 after PH6.
- SCR=1, VA=14'h1ABC -> page 7 bank1 gives {11,01101010111100}=16'hDABC: at PH0 MA=8'hBC, at PH1 MA=8'hDA, CASn=2'b01 during PH2-3.
- MREQn=0, WRn=1, A=16'hC123, PAGE=3 sampled at PH4 -> MA=8'h23 then 8'hC1, CASn=2'b10 during PH6-7, CLATCH=1 at PH7, WEn=1.
- MREQn=0, WRn=0, A=16'h8005 -> page 2: WEn=0 during PH5-7, CASn=2'b10 during PH6-7, no CLATCH; WRn raised at PH5 does not change WEn.
- A=16'h0100 with MREQn=0 and REF_PEND=1 -> ROM access ignored, refresh cycle runs instead.
- Assert RESETn at PH6 of a CPU write -> RASn, CASn and WEn go high without waiting for CLK; after release PH starts at 0.
